c2c_data_ram: RTL and testbench

Single-port, byte-enabled data memory acting as the responder (slave) on the `c2c_data` bus. It accepts one load or store at a time from the core's load store unit and acknowledges it after a programmable number of wait cycles. It sits outside the processor core, alongside the instruction memory. It is the standard memory model for core simulation and the on-chip data SRAM for FPGA builds.

---
 rtl/c2c_pkg.sv | 12 +
 rtl/c2c_data.sv | 14 +
 rtl/ram_array.sv | 22 ++
 rtl/c2c_data_ram.sv | 80 ++++++++
 tb/tb_c2c_data_ram.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/c2c_pkg.sv
// c2c_pkg: shared types and constants for the c2c data memory responder
package c2c_pkg;
  localparam int C2C_XLEN = 32;
  localparam int C2C_MAX_WAIT = 15;
  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT, RESP} c2c_ram_state_e;
  typedef struct packed {
    logic [C2C_XLEN-1:0] addr;
    logic [C2C_XLEN/8-1:0] be;
    logic [C2C_XLEN-1:0] wdata;
    logic is_write;
  } c2c_req_t;
endpackage

// File: rtl/c2c_data.sv
// c2c_data: load/store bus between the core LSU (master) and data memory (slave)
interface c2c_data #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic [XLEN/8-1:0] be;
  logic re;
  logic we;
  logic ack;
  modport master (output addr, re, we, be, wdata, input rdata, ack);
  modport slave (input addr, re, we, be, wdata, output rdata, ack);
endinterface

// File: rtl/ram_array.sv
// ram_array: single-port byte-write synchronous-read array, shaped for block RAM inference
module ram_array #(
  parameter int XLEN = 32,
  parameter int DEPTH = 1024,
  parameter string INIT_FILE = "",
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [XLEN/8-1:0] we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);
  logic [XLEN-1:0] mem [DEPTH];
  always @(posedge clk)
    if (en_i)
      for (int i = 0; i < XLEN / 8; i++)
        if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  always_ff @(posedge clk)
    if (en_i) rdata_o <= mem[addr_i];
endmodule

// File: rtl/c2c_data_ram.sv
// c2c_data_ram: byte-enabled data SRAM answering one c2c_data request at a time
// after a fixed number of wait cycles; flags out-of-range and re+we conflicts.
module c2c_data_ram
  import c2c_pkg::*;
#(
  parameter int XLEN = C2C_XLEN,
  parameter int DEPTH = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 1,
  parameter string INIT_FILE = ""
) (
  input  logic   clk,
  input  logic   reset,
  c2c_data.slave data_bus,
  output logic   fault
);
  localparam int LB = $clog2(XLEN / 8);
  localparam int AW = $clog2(DEPTH);
  localparam int WAIT_EFF = WAIT_CYCLES > C2C_MAX_WAIT ? C2C_MAX_WAIT : WAIT_CYCLES;
  localparam logic [3:0] WAIT_LOAD = WAIT_EFF > 0 ? 4'(WAIT_EFF - 1) : 4'd0;
  c2c_ram_state_e state_q;
  c2c_req_t req_q;
  logic conflict_q, ack_q, fault_q;
  logic [3:0] cnt_q;
  logic [XLEN-1:0] rdata_q, ram_rdata, off;
  logic hit, wr_commit, unused_lo;
  assign off = req_q.addr - BASE_ADDR;
  assign hit = off[XLEN-1:AW+LB] == '0;
  assign unused_lo = ^off[LB-1:0];
  // the write lands on the RESP edge, even if reset arrives on that same edge
  assign wr_commit = state_q == RESP && req_q.is_write && hit;
  ram_array #(
    .XLEN(XLEN),
    .DEPTH(DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(clk),
    .en_i(state_q == CAPTURE || state_q == RESP),
    .we_i(wr_commit ? req_q.be : '0),
    .addr_i(off[AW+LB-1:LB]),
    .wdata_i(req_q.wdata),
    .rdata_o(ram_rdata)
  );
  assign data_bus.ack = ack_q;
  assign data_bus.rdata = state_q == RESP ? (hit ? ram_rdata : '0) : rdata_q;
  assign fault = fault_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (data_bus.re || data_bus.we) begin
          req_q <= '{addr: data_bus.addr, be: data_bus.be, wdata: data_bus.wdata, is_write: data_bus.we};
          conflict_q <= data_bus.re && data_bus.we;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          fault_q <= fault_q | ~hit | conflict_q;
          cnt_q <= WAIT_LOAD;
          state_q <= WAIT_EFF > 0 ? WAIT : RESP;
          ack_q <= WAIT_EFF == 0;
        end
        WAIT: if (cnt_q == '0) begin
          state_q <= RESP;
          ack_q <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        RESP: begin
          rdata_q <= data_bus.rdata;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2c_data_ram.sv
// tb_c2c_data_ram: drives three builds (0, 1 and 15 wait cycles) against a word-level memory model
module tb_c2c_data_ram;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] re_v = '0, we_v = '0;
  logic [31:0] addr_v [3];
  logic [31:0] wdata_v [3];
  logic [3:0] be_v [3];
  logic [2:0] ack_v, fault_v;
  logic [31:0] rdata_v [3];
  int checks = 0, failures = 0;
  logic [31:0] mem_m [int];
  bit fault_m [3];
  logic [31:0] rd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    c2c_data #(.XLEN(32)) bus ();
    assign bus.re = re_v[g];
    assign bus.we = we_v[g];
    assign bus.addr = addr_v[g];
    assign bus.be = be_v[g];
    assign bus.wdata = wdata_v[g];
    assign ack_v[g] = bus.ack;
    assign rdata_v[g] = bus.rdata;
    c2c_data_ram #(
      .XLEN(32),
      .DEPTH(g == 1 ? 1024 : 64),
      .BASE_ADDR(g == 0 ? 32'h0000_4000 : 32'h0),
      .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 1 : 15),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .data_bus(bus),
      .fault(fault_v[g])
    );
  end

  function automatic int wt(input int d);
    return d == 0 ? 0 : d == 1 ? 1 : 15;
  endfunction

  function automatic logic [31:0] base(input int d);
    return d == 0 ? 32'h0000_4000 : 32'h0;
  endfunction

  function automatic longint span(input int d);
    return d == 1 ? 4096 : 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_write(input int d, input logic [31:0] addr, input logic [3:0] be,
                                      input logic [31:0] wd);
    logic [31:0] off, w;
    int key;
    off = addr - base(d);
    if (longint'(off) >= span(d)) return;
    key = d * 65536 + int'(off >> 2);
    w = mem_m.exists(key) ? mem_m[key] : 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem_m[key] = w;
  endfunction

  task automatic txn(input int d, input bit re, input bit we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input string tag,
                     output logic [31:0] got);
    int lat, pulses, key;
    bit seen, inr;
    logic [31:0] off, exp_rd;
    @(negedge clk);
    re_v[d] = re; we_v[d] = we; addr_v[d] = addr; be_v[d] = be; wdata_v[d] = wd;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = ack_v[d];
    end
    got = rdata_v[d];
    @(posedge clk); #1;
    re_v[d] = 0; we_v[d] = 0;
    pulses = 0;
    repeat (wt(d) + 3) begin
      @(posedge clk); #1;
      if (ack_v[d]) pulses++;
    end
    off = addr - base(d);
    inr = longint'(off) < span(d);
    key = d * 65536 + int'(off >> 2);
    exp_rd = inr ? (mem_m.exists(key) ? mem_m[key] : got) : 32'h0;
    if (we) model_write(d, addr, be, wd);
    if (!inr || (re && we)) fault_m[d] = 1;
    check({tag, " latency"}, lat, wt(d) + 2);
    check({tag, " extra ack"}, pulses, 0);
    if (!we) check({tag, " rdata"}, got, exp_rd);
    check({tag, " fault"}, {31'b0, fault_v[d]}, {31'b0, fault_m[d]});
  endtask

  task automatic rst_txn(input logic [31:0] addr, input logic [31:0] wd, input int edges,
                         input string tag);
    int pulses;
    @(negedge clk);
    we_v[1] = 1; addr_v[1] = addr; be_v[1] = 4'hF; wdata_v[1] = wd;
    repeat (edges) @(posedge clk);
    #1;
    reset = 1; re_v[1] = 0; we_v[1] = 0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack_v[1]) pulses++;
    end
    @(negedge clk) reset = 0;
    if (edges == 3) model_write(1, addr, 4'hF, wd);
    for (int d = 0; d < 3; d++) fault_m[d] = 0;
    check({tag, " ack"}, pulses, 0);
    check({tag, " fault"}, {31'b0, fault_v[1]}, 32'h0);
    check({tag, " rdata"}, rdata_v[1], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] a;
    for (int d = 0; d < 3; d++) begin
      addr_v[d] = '0; wdata_v[d] = '0; be_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ack%0d", d), {31'b0, ack_v[d]}, 32'h0);
      check($sformatf("reset rdata%0d", d), rdata_v[d], 32'h0);
      check($sformatf("reset fault%0d", d), {31'b0, fault_v[d]}, 32'h0);
    end
    txn(1, 0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, "wr10", rd);
    txn(1, 1, 0, 32'h10, 4'hF, 32'h0, "rd10", rd);
    check("rd10 value", rd, 32'hDEAD_BEEF);
    txn(1, 0, 1, 32'h20, 4'hF, 32'h1122_3344, "wr20", rd);
    txn(1, 0, 1, 32'h20, 4'b0100, 32'h00AA_0000, "wr20 lane2", rd);
    txn(1, 1, 0, 32'h23, 4'b0001, 32'h0, "rd20", rd);
    check("rd20 value", rd, 32'h11AA_3344);
    txn(1, 0, 1, 32'h20, 4'b0000, 32'hFFFF_FFFF, "wr20 be0", rd);
    txn(1, 1, 0, 32'h20, 4'hF, 32'h0, "rd20 be0", rd);
    txn(1, 0, 1, 32'h30, 4'hF, 32'h1, "wr30", rd);
    rst_txn(32'h30, 32'hBAD0_BAD0, 2, "rst wait");
    txn(1, 1, 0, 32'h30, 4'hF, 32'h0, "rd30", rd);
    check("rd30 value", rd, 32'h1);
    txn(1, 0, 1, 32'h34, 4'hF, 32'h0, "wr34", rd);
    rst_txn(32'h34, 32'h77, 3, "rst resp");
    txn(1, 1, 0, 32'h34, 4'hF, 32'h0, "rd34", rd);
    check("rd34 value", rd, 32'h77);
    txn(1, 1, 0, 32'h1000, 4'hF, 32'h0, "rd oob", rd);
    txn(1, 0, 1, 32'h44, 4'hF, 32'h99, "wr44", rd);
    txn(1, 1, 0, 32'h44, 4'hF, 32'h0, "rd44", rd);
    check("rd44 value", rd, 32'h99);
    txn(1, 0, 1, 32'h1004, 4'hF, 32'h1234, "wr oob", rd);
    txn(1, 1, 0, 32'h4, 4'hF, 32'h0, "rd wrap", rd);
    rst_txn(32'h3C, 32'h3C3C, 3, "rst clr");
    txn(1, 1, 1, 32'h40, 4'hF, 32'h5, "rw40", rd);
    txn(1, 1, 0, 32'h40, 4'hF, 32'h0, "rd40", rd);
    check("rd40 value", rd, 32'h5);
    for (int i = 0; i < 16; i++) txn(1, 0, 1, 32'h100 + 32'(i) * 4, 4'hF, $urandom, "fill", rd);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if (k >= 8)
        a = $urandom_range(0, 1) != 0 ? 32'h1000 + 32'($urandom_range(0, 4095))
                                      : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      txn(1, k < 4 || k == 7 || k == 8, k >= 4 && k != 8, a, 4'($urandom), $urandom,
          $sformatf("rnd%0d", n), rd);
    end
    txn(0, 0, 1, 32'h4008, 4'hF, 32'hCAFE_F00D, "w0 wr", rd);
    txn(0, 1, 0, 32'h4008, 4'hF, 32'h0, "w0 rd", rd);
    check("w0 rd value", rd, 32'hCAFE_F00D);
    txn(0, 1, 0, 32'h3FFC, 4'hF, 32'h0, "w0 below base", rd);
    txn(0, 1, 0, 32'h4100, 4'hF, 32'h0, "w0 above top", rd);
    txn(2, 0, 1, 32'hFC, 4'hF, 32'h0BAD_CAFE, "w15 wr", rd);
    txn(2, 1, 0, 32'hFC, 4'hF, 32'h0, "w15 rd", rd);
    check("w15 rd value", rd, 32'h0BAD_CAFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
